// File: rtl/int_priority_ctrl.sv
// Interrupt priority controller: rising-edge request capture into a pending register,
// masked fixed-priority or round-robin arbitration, and a two-state serve/acknowledge FSM.
module int_priority_ctrl #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            m,
  input  logic            rr,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic [N*W-1:0]  vec,
  input  logic            ack,
  output logic            irq,
  output logic [IW-1:0]   id,
  output logic [W-1:0]    y,
  output logic [N-1:0]    pend
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [N-1:0]  r_req_d;
  logic          r_armed;
  logic [N-1:0]  r_pend;
  logic [IW-1:0] r_id;
  logic [W-1:0]  r_y;
  logic [IW-1:0] r_ptr;

  logic [N-1:0]  w_rise;
  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_elig_hi;
  logic [N-1:0]  w_pend_nxt;
  logic [IW-1:0] w_grant_id;
  logic [W-1:0]  w_grant_vec;
  logic [IW-1:0] w_ptr_nxt;
  logic          w_grant_vld;
  logic          w_do_grant;
  logic          w_do_ack;

  // Returns the index of the lowest set bit of v (0 when v is empty).
  function automatic logic [IW-1:0] f_lowest(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    logic          found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i] && !found) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // The first edge after reset release only loads the history, so a request
  // already high across release is never mistaken for a new rising edge.
  always_comb begin
    w_rise = '0;
    if (r_armed) begin
      w_rise = req & ~r_req_d;
    end
  end

  always_comb begin
    w_elig = '0;
    if (m) begin
      w_elig = r_pend & mask;
    end else begin
      w_elig[0] = r_pend[0] & mask[0];
    end
  end

  // Round-robin: prefer the lowest eligible index at or above ptr, else wrap
  // to the lowest eligible index overall.
  always_comb begin
    w_elig_hi = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_elig_hi[i] = w_elig[i] && (IW'(i) >= r_ptr);
    end
  end

  always_comb begin
    w_grant_vld = |w_elig;
    w_grant_id  = f_lowest(w_elig);
    if (m && rr && (|w_elig_hi)) begin
      w_grant_id = f_lowest(w_elig_hi);
    end
  end

  always_comb begin
    w_grant_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IW'(i) == w_grant_id) begin
        w_grant_vec = vec[i*W +: W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    w_do_ack    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = BUSY;
          w_do_grant  = 1'b1;
        end
      end
      BUSY: begin
        if (ack) begin
          w_state_nxt = IDLE;
          w_do_ack    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Clear-on-ack is applied before the set so a coincident new edge keeps the bit.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_do_ack) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (IW'(i) == r_id) begin
          w_pend_nxt[i] = 1'b0;
        end
      end
    end
    w_pend_nxt = w_pend_nxt | w_rise;
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_do_ack) begin
      if (r_id == IW'(N - 1)) begin
        w_ptr_nxt = '0;
      end else begin
        w_ptr_nxt = r_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req_d <= '0;
      r_armed <= 1'b0;
      r_pend  <= '0;
      r_id    <= '0;
      r_y     <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req_d <= req;
      r_armed <= 1'b1;
      r_pend  <= w_pend_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_do_grant) begin
        r_id <= w_grant_id;
        r_y  <= w_grant_vec;
      end
    end
  end

  assign irq  = (r_state == BUSY);
  assign id   = r_id;
  assign y    = r_y;
  assign pend = r_pend;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed self-checking bench for int_priority_ctrl (N=4, W=8).
module tb_int_priority_ctrl;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clock;
  logic           reset_n;
  logic           m;
  logic           rr;
  logic [N-1:0]   req;
  logic [N-1:0]   mask;
  logic [N*W-1:0] vec;
  logic           ack;
  logic           irq;
  logic [IW-1:0]  id;
  logic [W-1:0]   y;
  logic [N-1:0]   pend;

  int checks;
  int passed;

  localparam logic [N*W-1:0] VEC_STD = {8'h44, 8'h33, 8'h22, 8'h11};

  int unsigned exp_ids [5] = '{0, 1, 2, 3, 0};
  logic [7:0]  exp_ys  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

  int_priority_ctrl #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .m       (m),
    .rr      (rr),
    .req     (req),
    .mask    (mask),
    .vec     (vec),
    .ack     (ack),
    .irq     (irq),
    .id      (id),
    .y       (y),
    .pend    (pend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    reset_n = 1'b0;
    m       = 1'b1;
    rr      = 1'b0;
    req     = '0;
    mask    = 4'b1111;
    vec     = VEC_STD;
    ack     = 1'b0;

    step();
    step();
    chk("rst_irq",  32'(irq),  32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_id",   32'(id),   32'd0);
    chk("rst_y",    32'(y),    32'd0);
    reset_n = 1'b1;
    step();

    // single channel
    req = 4'b0100;
    step();
    chk("single_pend_k",  32'(pend), 32'b0100);
    chk("single_irq_k",   32'(irq),  32'd0);
    step();
    chk("single_irq_k1",  32'(irq),  32'd1);
    chk("single_id",      32'(id),   32'd2);
    chk("single_y",       32'(y),    32'h33);
    ack = 1'b1;
    step();
    chk("single_ack_irq",  32'(irq),  32'd0);
    chk("single_ack_pend", 32'(pend), 32'd0);
    ack = 1'b0;
    req = '0;
    step();

    // fixed priority, grant held against input changes
    req = 4'b0101;
    step();
    chk("fp_pend", 32'(pend), 32'b0101);
    step();
    chk("fp_irq0", 32'(irq), 32'd1);
    chk("fp_id0",  32'(id),  32'd0);
    chk("fp_y0",   32'(y),   32'h11);
    mask = 4'b0000;
    vec  = '1;
    rr   = 1'b1;
    step();
    chk("fp_hold_id", 32'(id), 32'd0);
    chk("fp_hold_y",  32'(y),  32'h11);
    chk("fp_hold_irq", 32'(irq), 32'd1);
    mask = 4'b1111;
    vec  = VEC_STD;
    rr   = 1'b0;
    ack  = 1'b1;
    step();
    chk("fp_gap_irq",  32'(irq),  32'd0);
    chk("fp_gap_pend", 32'(pend), 32'b0100);
    ack = 1'b0;
    step();
    chk("fp_irq2", 32'(irq), 32'd1);
    chk("fp_id2",  32'(id),  32'd2);
    chk("fp_y2",   32'(y),   32'h33);
    ack = 1'b1;
    step();
    chk("fp_done_pend", 32'(pend), 32'd0);
    ack = 1'b0;
    req = '0;

    // round-robin from a fresh pointer
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rr      = 1'b1;
    step();
    req = 4'b1111;
    step();
    chk("rr_pend", 32'(pend), 32'b1111);
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_irq_%0d", k), 32'(irq), 32'd1);
      chk($sformatf("rr_id_%0d", k),  32'(id),  32'(exp_ids[k]));
      chk($sformatf("rr_y_%0d", k),   32'(y),   32'(exp_ys[k]));
      if (k < 4) begin
        ack = 1'b1;
        req = '0;
        step();
        chk($sformatf("rr_gap_%0d", k), 32'(irq), 32'd0);
        ack = 1'b0;
        req = 4'b1111;
        step();
      end
    end
    reset_n = 1'b0;
    req     = '0;
    step();
    chk("rst2_irq",  32'(irq),  32'd0);
    chk("rst2_pend", 32'(pend), 32'd0);
    reset_n = 1'b1;
    m       = 1'b0;
    rr      = 1'b0;
    step();

    // mode 0 and masking
    req = 4'b0110;
    step();
    chk("m0_pend", 32'(pend), 32'b0110);
    step();
    chk("m0_noirq", 32'(irq), 32'd0);
    mask = 4'b1110;
    req  = 4'b0111;
    step();
    chk("m0_pend0", 32'(pend), 32'b0111);
    ack = 1'b1;
    step();
    chk("idle_ack_irq",  32'(irq),  32'd0);
    chk("idle_ack_pend", 32'(pend), 32'b0111);
    ack  = 1'b0;
    mask = 4'b1111;
    step();
    chk("unmask_irq", 32'(irq), 32'd1);
    chk("unmask_id",  32'(id),  32'd0);
    chk("unmask_y",   32'(y),   32'h11);
    ack = 1'b1;
    step();
    chk("m0_ack_irq",  32'(irq),  32'd0);
    chk("m0_ack_pend", 32'(pend), 32'b0110);
    ack = 1'b0;
    m   = 1'b1;
    step();
    chk("m1_irq", 32'(irq), 32'd1);
    chk("m1_id",  32'(id),  32'd1);
    chk("m1_y",   32'(y),   32'h22);

    // ack coincident with a new rising edge on the served channel
    req = 4'b0101;
    step();
    chk("co_busy_id", 32'(id), 32'd1);
    ack = 1'b1;
    req = 4'b0111;
    step();
    chk("co_irq",  32'(irq),  32'd0);
    chk("co_pend", 32'(pend), 32'b0110);
    ack = 1'b0;
    step();
    chk("co_regrant_irq", 32'(irq), 32'd1);
    chk("co_regrant_id",  32'(id),  32'd1);

    // reset mid-BUSY with ack, request held high through release
    ack     = 1'b1;
    reset_n = 1'b0;
    step();
    chk("rmb_irq",  32'(irq),  32'd0);
    chk("rmb_pend", 32'(pend), 32'd0);
    chk("rmb_id",   32'(id),   32'd0);
    chk("rmb_y",    32'(y),    32'd0);
    reset_n = 1'b1;
    ack     = 1'b0;
    step();
    step();
    step();
    chk("rmb_held_irq",  32'(irq),  32'd0);
    chk("rmb_held_pend", 32'(pend), 32'd0);
    req = '0;
    rr  = 1'b1;
    step();
    req = 4'b1001;
    step();
    chk("rmb_ptr_pend", 32'(pend), 32'b1001);
    step();
    chk("rmb_ptr_irq", 32'(irq), 32'd1);
    chk("rmb_ptr_id",  32'(id),  32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/int_priority_ctrl.md
INT_PRIORITY_CTRL -- requirements
Module: int_priority_ctrl

Interface
REQ-001 Parameter N, default 4: number of interrupt channels, legal range 1..16.
REQ-002 Parameter W, default 8: width of each channel's vector word, legal range 1..32.
REQ-003 Parameter IW, default 2: width of the id output, equal to max(1, clog2(N)).
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port m, input, 1 bit: mode select; 0 = channel 0 only, 1 = arbitration across all channels.
REQ-007 Port rr, input, 1 bit: arbitration policy when m=1; 0 = fixed priority, 1 = round-robin.
REQ-008 Port req, input, N bits: level interrupt request lines, one per channel.
REQ-009 Port mask, input, N bits: per-channel enable; 1 = channel eligible.
REQ-010 Port vec, input, N*W bits: vector words; channel i occupies bits [i*W+W-1 : i*W].
REQ-011 Port ack, input, 1 bit: acknowledge strobe for the interrupt currently being served.
REQ-012 Port irq, output, 1 bit: interrupt outstanding to the consumer.
REQ-013 Port id, output, IW bits: index of the channel being served.
REQ-014 Port y, output, W bits: vector word of the channel being served.
REQ-015 Port pend, output, N bits: pending register, for observation.

Function
REQ-016 The block SHALL register req every cycle and set pend[i] on the edge where req[i] is high and was low on the previous sample, which is rising-edge capture.
REQ-017 A pend bit SHALL stay set until its channel is acknowledged or reset occurs, independent of req and mask.
REQ-018 Eligible set: with m=0, pend[0]&mask[0] only; with m=1, pend&mask.
REQ-019 The FSM SHALL have two states: IDLE (irq=0) and BUSY (irq=1).
REQ-020 In IDLE, if the eligible set is non-empty at an edge, the block SHALL enter BUSY and register id, and register y from vec of the granted channel.
REQ-021 With rr=0 or m=0, the lowest eligible index SHALL win.
REQ-022 With rr=1 and m=1, the first eligible index at or after ptr SHALL win, searching with wrap from N-1 to 0.
REQ-023 ptr SHALL have IW bits and reset to 0; on each ack in BUSY, ptr SHALL become (id+1) mod N.
REQ-024 id and y SHALL hold stable throughout BUSY; changes on vec, mask, m or rr in BUSY SHALL not affect the current grant.
REQ-025 In BUSY, ack=1 at an edge SHALL clear pend[id] and return the FSM to IDLE with irq=0.
REQ-026 A new arbitration SHALL occur no earlier than the edge after that return, so irq is low for at least one cycle between grants.
REQ-027 ack in IDLE SHALL be ignored.
REQ-028 If a rising edge on channel id coincides with its ack, set SHALL win and pend[id] SHALL remain 1.
REQ-029 Latency: a req rising edge sampled at edge k sets pend after edge k; irq rises after edge k+1 if the FSM is IDLE and the channel wins.
REQ-030 Masked pending channels SHALL be served once unmasked; masking a channel SHALL not retract a grant already made.
REQ-031 N=1 SHALL be legal: id is constantly 0 and rr has no effect.

Reset
REQ-032 reset_n=0 at an edge SHALL force IDLE and irq=0, and clear pend, id, y, ptr and the req history register to 0.
REQ-033 reset SHALL take priority over every event, including mid-BUSY and a coincident ack.
REQ-034 After release, a req already high SHALL not be captured; it must first go low, then high.

Verification
REQ-035 Bench, single channel: N=4, m=1, rr=0, mask=1111, vec={8'h44,8'h33,8'h22,8'h11}, req[2] rises at edge k -> pend=0100 after k; irq=1, id=2, y=8'h33 after k+1; ack -> irq=0, pend=0000.
REQ-036 Bench, fixed priority: req 0101 rise together, rr=0 -> grant id=0 (y=8'h11), ack, one idle cycle, then grant id=2 (y=8'h33).
REQ-037 Bench, round-robin: pend=1111 held by repeated edges, rr=1 -> grants occur in order 0,1,2,3,0 across successive acks.
REQ-038 Bench, mode 0 and mask: m=0, req 0110 rise -> no irq; then req[0] rises with mask[0]=0 -> no irq until mask[0]=1, then id=0.
REQ-039 Bench, coincident events: in BUSY on id=1, ack coincides with a new req[1] rising edge -> after the edge irq=0 and pend[1]=1; one edge later id=1 is regranted.
REQ-040 Bench, reset mid-BUSY: reset_n=0 one edge while irq=1 with ack=1 -> irq=0, pend=0, ptr=0; a req held high through release produces no interrupt.
